count_sampler_ctrl: RTL and testbench

Avalon-MM controlled sampling scheduler for the free-running 32-bit count input of the SoC. It captures `in_port` on a programmable period or on a software trigger and buffers the snapshots in a DEPTH-entry FIFO. The HPS drains the FIFO over a 4-word register window with fixed read latency 1, and is interrupted on a fill-level threshold or on overflow. It sits on the lightweight HPS-to-FPGA bridge, next to the count PIO, and replaces polled single reads.

---
 rtl/count_sampler_ctrl_if.sv | 33 +++
 rtl/count_sampler_ctrl.sv | 202 ++++++++++++++++++++
 tb/tb_count_sampler_ctrl.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/count_sampler_ctrl_if.sv
// rtl/count_sampler_ctrl_if.sv - Avalon-MM register window bundle for count_sampler_ctrl
//
// Signals:
//   address   [1:0]  word address of the 4-word register window
//   write            write strobe, one cycle per access
//   writedata [31:0] write data
//   read             read strobe, one cycle per access
//   readdata  [31:0] registered read data, valid the cycle after read
// Modports: master (HPS bridge side), slave (count_sampler_ctrl side).

interface count_sampler_ctrl_if;
    logic [1:0]  address;
    logic        write;
    logic [31:0] writedata;
    logic        read;
    logic [31:0] readdata;

    modport master (
        output address,
        output write,
        output writedata,
        output read,
        input  readdata
    );

    modport slave (
        input  address,
        input  write,
        input  writedata,
        input  read,
        output readdata
    );
endinterface

// File: rtl/count_sampler_ctrl.sv
// rtl/count_sampler_ctrl.sv - periodic/triggered sampler of in_port into a FIFO drained over Avalon-MM
//
// Captures in_port every PERIOD+1 cycles while running, or one cycle after a
// software trigger, and buffers the samples in a DEPTH-entry FIFO.
//
// Ports:
//   clk      system clock
//   reset_n  asynchronous active-low reset
//   bus      Avalon-MM register window (count_sampler_ctrl_if.slave)
//              addr 0 CTRL   [0] run, [1] irq_en, [2] trig (pulse, reads 0), [7:4] thr
//              addr 1 PERIOD sample interval minus one
//              addr 2 STATUS [LVL_W-1:0] level, [8] empty, [9] full, [10] ovf (W1C)
//              addr 3 DATA   read pops FIFO head; 0 when empty
//   in_port  free-running count input
//   irq      registered level interrupt
//
// Build option: COUNT_SAMPLER_DELTA_EN stores in_port minus the previous
// captured value instead of the raw count.

module count_sampler_ctrl #(
    parameter int DEPTH = 8,
    localparam int LVL_W = $clog2(DEPTH) + 1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    count_sampler_ctrl_if.slave   bus,
    input  logic [31:0]           in_port,
    output logic                  irq
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(DEPTH);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t            state;
    logic              irq_en;
    logic [3:0]        thr;
    logic [31:0]       period;
    logic [31:0]       timer;
    logic              trig_q;
    logic              ovf;
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [LVL_W-1:0]  level;
    logic [31:0]       mem [DEPTH];

    logic              ctrl_wr;
    logic              period_wr;
    logic              status_wr;
    logic              data_rd;
    logic              run_start;
    logic              run_stop;
    logic              timer_fire;
    logic              capture;
    logic              empty;
    logic              full;
    logic              pop;
    logic              push;
    logic [31:0]       sample;
    logic [31:0]       status_word;
    logic [31:0]       ctrl_word;

    assign ctrl_wr   = bus.write && (bus.address == 2'd0);
    assign period_wr = bus.write && (bus.address == 2'd1);
    assign status_wr = bus.write && (bus.address == 2'd2);
    assign data_rd   = bus.read  && (bus.address == 2'd3);

    assign run_start = ctrl_wr &&  bus.writedata[0] && (state == IDLE);
    assign run_stop  = ctrl_wr && !bus.writedata[0] && (state == RUN);

    // A stop written in the same cycle as an expiry cancels that capture.
    assign timer_fire = (state == RUN) && (timer == 32'd0) && !run_stop;
    assign capture    = timer_fire || trig_q;

    assign empty = (level == '0);
    assign full  = (level == FULL_LVL);
    // Pop is evaluated first so a capture on a full FIFO still lands when a
    // DATA read drains the head in the same cycle.
    assign pop   = data_rd && !empty;
    assign push  = capture && (!full || pop);

`ifdef COUNT_SAMPLER_DELTA_EN
    logic [31:0] prev;
    assign sample = in_port - prev;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prev <= '0;
        end else if (push || run_start ||
                     (ctrl_wr && bus.writedata[2] && (state == IDLE))) begin
            prev <= in_port;
        end
    end
`else
    assign sample = in_port;
`endif

    always_comb begin
        status_word                = '0;
        status_word[LVL_W-1:0]     = level;
        status_word[8]             = empty;
        status_word[9]             = full;
        status_word[10]            = ovf;
    end

    always_comb begin
        ctrl_word      = '0;
        ctrl_word[0]   = (state == RUN);
        ctrl_word[1]   = irq_en;
        ctrl_word[7:4] = thr;
    end

    // Sample storage carries no reset; pointers and level define validity.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= sample;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            irq_en       <= 1'b0;
            thr          <= '0;
            period       <= '0;
            timer        <= '0;
            trig_q       <= 1'b0;
            ovf          <= 1'b0;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            level        <= '0;
            irq          <= 1'b0;
            bus.readdata <= '0;
        end else begin
            trig_q <= ctrl_wr && bus.writedata[2];

            if (ctrl_wr) begin
                irq_en <= bus.writedata[1];
                thr    <= bus.writedata[7:4];
            end

            // A running timer keeps the old period until its next reload.
            if (period_wr) begin
                period <= bus.writedata;
            end

            case (state)
                IDLE: begin
                    if (run_start) begin
                        state <= RUN;
                        timer <= period;
                    end
                end
                RUN: begin
                    if (run_stop) begin
                        state <= IDLE;
                    end else if (timer == 32'd0) begin
                        timer <= period;
                    end else begin
                        timer <= timer - 32'd1;
                    end
                end
                default: state <= IDLE;
            endcase

            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase

            // A new overflow outranks a simultaneous clear.
            if (capture && full && !pop) begin
                ovf <= 1'b1;
            end else if (status_wr && bus.writedata[10]) begin
                ovf <= 1'b0;
            end

            irq <= irq_en && (((thr != 4'd0) && (5'(level) >= {1'b0, thr})) || ovf);

            if (bus.read) begin
                case (bus.address)
                    2'd0:    bus.readdata <= ctrl_word;
                    2'd1:    bus.readdata <= period;
                    2'd2:    bus.readdata <= status_word;
                    default: bus.readdata <= empty ? 32'd0 : mem[rd_ptr];
                endcase
            end
        end
    end

endmodule

// File: tb/tb_count_sampler_ctrl.sv
// tb/tb_count_sampler_ctrl.sv - self-checking bench for count_sampler_ctrl

module tb_count_sampler_ctrl;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [31:0] in_port = 32'h0000_1000;
    logic        irq;

    count_sampler_ctrl_if bus_if ();

    count_sampler_ctrl #(.DEPTH(8)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus_if.slave),
        .in_port (in_port),
        .irq     (irq)
    );

    always #5 clk = ~clk;

    // Count input advances once per cycle, well clear of both clock edges.
    always @(posedge clk) begin
        #2 in_port = in_port + 32'd1;
    end

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic        wr;
        logic [1:0]  addr;
        logic [31:0] data;
        logic [31:0] exp;
    } vec_t;

    vec_t tbl [14];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Tasks start and end on a falling edge; each access occupies one cycle.
    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        bus_if.address   = a;
        bus_if.writedata = d;
        bus_if.write     = 1'b1;
        @(negedge clk);
        bus_if.write     = 1'b0;
    endtask

    task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
        bus_if.address = a;
        bus_if.read    = 1'b1;
        @(negedge clk);
        bus_if.read    = 1'b0;
        d = bus_if.readdata;
    endtask

    function automatic logic [31:0] ev(input logic [31:0] raw, input logic [31:0] dlt);
`ifdef COUNT_SAMPLER_DELTA_EN
        return dlt;
`else
        return raw;
`endif
    endfunction

    logic [31:0] rd;
    logic [31:0] w;
    logic [31:0] wt;

    initial begin
        bus_if.address   = '0;
        bus_if.write     = 1'b0;
        bus_if.writedata = '0;
        bus_if.read      = 1'b0;

        tbl[0]  = '{1'b0, 2'd0, 32'h0,          32'h0};
        tbl[1]  = '{1'b0, 2'd1, 32'h0,          32'h0};
        tbl[2]  = '{1'b0, 2'd2, 32'h0,          32'h100};
        tbl[3]  = '{1'b0, 2'd3, 32'h0,          32'h0};
        tbl[4]  = '{1'b1, 2'd1, 32'h1234_5678,  32'h0};
        tbl[5]  = '{1'b0, 2'd1, 32'h0,          32'h1234_5678};
        tbl[6]  = '{1'b1, 2'd0, 32'h0000_00F2,  32'h0};
        tbl[7]  = '{1'b0, 2'd0, 32'h0,          32'h0000_00F2};
        tbl[8]  = '{1'b1, 2'd0, 32'hFFFF_FF0A,  32'h0};
        tbl[9]  = '{1'b0, 2'd0, 32'h0,          32'h0000_0002};
        tbl[10] = '{1'b1, 2'd3, 32'h0000_DEAD,  32'h0};
        tbl[11] = '{1'b0, 2'd2, 32'h0,          32'h100};
        tbl[12] = '{1'b1, 2'd0, 32'h0,          32'h0};
        tbl[13] = '{1'b0, 2'd0, 32'h0,          32'h0};

        repeat (3) @(negedge clk);
        check("reset_readdata", bus_if.readdata, 32'h0);
        check("reset_irq", {31'd0, irq}, 32'h0);
        reset_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 14; i++) begin
            if (tbl[i].wr) begin
                bus_write(tbl[i].addr, tbl[i].data);
            end else begin
                bus_read(tbl[i].addr, rd);
                check($sformatf("tbl%0d_addr%0d", i, tbl[i].addr), rd, tbl[i].exp);
            end
        end
        check("regs_irq", {31'd0, irq}, 32'h0);

        // Periodic capture every 10 cycles
        bus_write(2'd1, 32'd9);
        w = in_port;
        bus_write(2'd0, 32'h1);
        repeat (30) @(negedge clk);
        for (int k = 1; k <= 3; k++) begin
            bus_read(2'd3, rd);
            check($sformatf("period_sample%0d", k), rd, ev(w + 32'(10 * k), 32'd10));
        end
        bus_write(2'd0, 32'h0);
        repeat (12) @(negedge clk);
        bus_read(2'd2, rd);
        check("period_stopped_status", rd, 32'h100);

        // Overflow with PERIOD=0, run 20 cycles without reads
        bus_write(2'd1, 32'd0);
        w = in_port;
        bus_write(2'd0, 32'h1);
        repeat (19) @(negedge clk);
        bus_write(2'd0, 32'h0);
        bus_read(2'd2, rd);
        check("ovf_status", rd, 32'h608);
        for (int k = 1; k <= 8; k++) begin
            bus_read(2'd3, rd);
            check($sformatf("ovf_sample%0d", k), rd, ev(w + 32'(k), 32'd1));
        end
        bus_read(2'd2, rd);
        check("drained_status", rd, 32'h500);
        bus_read(2'd3, rd);
        check("empty_data_read", rd, 32'h0);
        bus_write(2'd2, 32'h400);
        bus_read(2'd2, rd);
        check("ovf_cleared", rd, 32'h100);

        // Full FIFO with DATA read coincident with a triggered capture
        w = in_port;
        bus_write(2'd0, 32'h1);
        repeat (8) @(negedge clk);
        bus_write(2'd0, 32'h0);
        bus_write(2'd2, 32'h400);
        bus_read(2'd2, rd);
        check("refill_status", rd, 32'h208);
        wt = in_port;
        bus_write(2'd0, 32'h4);
        bus_read(2'd3, rd);
        check("coinc_head", rd, ev(w + 32'd1, 32'd1));
        bus_read(2'd2, rd);
        check("coinc_status", rd, 32'h208);
        for (int k = 2; k <= 8; k++) begin
            bus_read(2'd3, rd);
            check($sformatf("coinc_sample%0d", k), rd, ev(w + 32'(k), 32'd1));
        end
        bus_read(2'd3, rd);
        check("coinc_tail", rd, ev(wt + 32'd1, 32'd1));

        // Level threshold interrupt
        bus_write(2'd0, 32'h32);
        bus_write(2'd0, 32'h36);
        bus_write(2'd0, 32'h36);
        bus_write(2'd0, 32'h36);
        @(negedge clk);
        check("irq_not_yet", {31'd0, irq}, 32'h0);
        @(negedge clk);
        check("irq_rise", {31'd0, irq}, 32'h1);
        bus_read(2'd3, rd);
        check("irq_still_high", {31'd0, irq}, 32'h1);
        @(negedge clk);
        check("irq_fall", {31'd0, irq}, 32'h0);
        bus_read(2'd2, rd);
        check("irq_level2", rd, 32'h2);

        // Reset mid-run with level 5
        bus_write(2'd1, 32'd100);
        bus_write(2'd0, 32'h33);
        for (int k = 0; k < 4; k++) begin
            bus_write(2'd0, 32'h37);
        end
        bus_read(2'd3, rd);
        repeat (2) @(negedge clk);
        bus_read(2'd2, rd);
        check("prereset_status", rd, 32'h5);
        check("prereset_irq", {31'd0, irq}, 32'h1);
        #3 reset_n = 1'b0;
        #1;
        check("async_irq", {31'd0, irq}, 32'h0);
        check("async_readdata", bus_if.readdata, 32'h0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        bus_read(2'd2, rd);
        check("postreset_status", rd, 32'h100);
        bus_read(2'd0, rd);
        check("postreset_ctrl", rd, 32'h0);
        repeat (20) @(negedge clk);
        bus_read(2'd2, rd);
        check("postreset_idle", rd, 32'h100);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
